// File: rtl/time_digit_counter_pkg.sv
// Shared codes, state encodings and field limits for the time-of-day digit counter.
package time_digit_counter_pkg;

    localparam logic [3:0] CODE_A     = 4'd10;
    localparam logic [3:0] CODE_P     = 4'd11;
    localparam logic [3:0] CODE_BLANK = 4'd15;

    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_SET_HR  = 2'b01;
    localparam logic [1:0] ST_SET_MIN = 2'b10;

    localparam logic [4:0] HR_MAX  = 5'd23;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [5:0] SEC_MAX = 6'd59;

    typedef struct packed {
        logic [3:0] d5;
        logic [3:0] d4;
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
    } digits_t;

endpackage

// File: rtl/time_digit_counter_if.sv
// User keys, display mode and digit/state outputs of the time-of-day counter.
interface time_digit_counter_if;

    logic       mode_12h;
    logic       key_set;
    logic       key_inc;
    logic [3:0] digit5;
    logic [3:0] digit4;
    logic [3:0] digit3;
    logic [3:0] digit2;
    logic [3:0] digit1;
    logic [3:0] digit0;
    logic [1:0] state;
    logic       sec_tick;

    modport master (
        output mode_12h, key_set, key_inc,
        input  digit5, digit4, digit3, digit2, digit1, digit0, state, sec_tick
    );

    modport slave (
        input  mode_12h, key_set, key_inc,
        output digit5, digit4, digit3, digit2, digit1, digit0, state, sec_tick
    );

endinterface

// File: rtl/time_digit_counter_bin_to_bcd2.sv
// Splits a 0-59 binary value into two decimal digit codes.
module time_digit_counter_bin_to_bcd2 (
    input  logic [5:0] i_bin,
    output logic [3:0] o_tens_c,
    output logic [3:0] o_ones_c
);

    logic [3:0] w_rem;

    // Highest multiple of ten not exceeding the input wins.
    always_comb begin
        o_tens_c = 4'd0;
        w_rem    = 4'(i_bin);
        for (int k = 1; k <= 5; k++) begin
            if (i_bin >= 6'(10 * k)) begin
                o_tens_c = 4'(k);
                w_rem    = 4'(i_bin - 6'(10 * k));
            end
        end
        o_ones_c = w_rem;
    end

endmodule

// File: rtl/time_digit_counter.sv
// Hours/minutes/seconds counter with 12h/24h digit codes and a two-key set mode.
module time_digit_counter
    import time_digit_counter_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 50000000,
    parameter int unsigned BLINK_DIV = 12500000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    time_digit_counter_if.slave  bus
);

    localparam int unsigned PRE_W = $clog2(TICK_DIV);
    localparam int unsigned BLK_W = $clog2(BLINK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    logic [1:0]       r_state;
    logic [4:0]       r_hr;
    logic [5:0]       r_min;
    logic [5:0]       r_sec;
    logic [PRE_W-1:0] r_pre;
    logic [BLK_W-1:0] r_blk_cnt;
    logic             r_blk_hide;
    logic             r_sec_tick;
    digits_t          r_digits;

    logic [1:0]       w_state_nxt;
    logic [4:0]       w_hr_nxt;
    logic [5:0]       w_min_nxt;
    logic [5:0]       w_sec_nxt;
    logic [PRE_W-1:0] w_pre_nxt;
    logic [BLK_W-1:0] w_blk_cnt_nxt;
    logic             w_blk_hide_nxt;
    logic             w_blk_restart;
    logic             w_tick_nxt;
    digits_t          w_digits_nxt;

    logic [5:0]       w_hr_disp;
    logic             w_pm;
    logic [3:0]       w_hr_tens, w_hr_ones;
    logic [3:0]       w_min_tens, w_min_ones;
    logic [3:0]       w_sec_tens, w_sec_ones;

    // Next-state: timekeeping in RUN, field edits in the set states, blink timing.
    always_comb begin
        w_state_nxt    = r_state;
        w_hr_nxt       = r_hr;
        w_min_nxt      = r_min;
        w_sec_nxt      = r_sec;
        w_pre_nxt      = r_pre;
        w_blk_cnt_nxt  = r_blk_cnt;
        w_blk_hide_nxt = r_blk_hide;
        w_blk_restart  = 1'b0;
        w_tick_nxt     = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (bus.key_set) begin
                    w_state_nxt   = ST_SET_HR;
                    w_blk_restart = 1'b1;
                end else if (r_pre == PRE_LAST) begin
                    w_pre_nxt  = '0;
                    w_tick_nxt = 1'b1;
                    if (r_sec == SEC_MAX) begin
                        w_sec_nxt = '0;
                        if (r_min == MIN_MAX) begin
                            w_min_nxt = '0;
                            w_hr_nxt  = (r_hr == HR_MAX) ? 5'd0 : r_hr + 5'd1;
                        end else begin
                            w_min_nxt = r_min + 6'd1;
                        end
                    end else begin
                        w_sec_nxt = r_sec + 6'd1;
                    end
                end else begin
                    w_pre_nxt = r_pre + PRE_W'(1);
                end
            end
            ST_SET_HR: begin
                if (bus.key_set) begin
                    w_state_nxt   = ST_SET_MIN;
                    w_blk_restart = 1'b1;
                end else if (bus.key_inc) begin
                    w_hr_nxt      = (r_hr == HR_MAX) ? 5'd0 : r_hr + 5'd1;
                    w_blk_restart = 1'b1;
                end
            end
            ST_SET_MIN: begin
                if (bus.key_set) begin
                    // Leaving edit restarts the second so the next tick is a full period away.
                    w_state_nxt = ST_RUN;
                    w_sec_nxt   = '0;
                    w_pre_nxt   = '0;
                end else if (bus.key_inc) begin
                    w_min_nxt     = (r_min == MIN_MAX) ? 6'd0 : r_min + 6'd1;
                    w_blk_restart = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        if (w_blk_restart || (w_state_nxt == ST_RUN)) begin
            w_blk_cnt_nxt  = '0;
            w_blk_hide_nxt = 1'b0;
        end else if (r_blk_cnt == BLK_LAST) begin
            w_blk_cnt_nxt  = '0;
            w_blk_hide_nxt = ~r_blk_hide;
        end else begin
            w_blk_cnt_nxt = r_blk_cnt + BLK_W'(1);
        end
    end

    // Hour value as displayed: 0 and 12 show as 12 in 12h mode, afternoon hours fold down.
    always_comb begin
        w_hr_disp = {1'b0, r_hr};
        w_pm      = (r_hr >= 5'd12);
        if (bus.mode_12h) begin
            if (r_hr == 5'd0) begin
                w_hr_disp = 6'd12;
            end else if (r_hr > 5'd12) begin
                w_hr_disp = 6'(r_hr - 5'd12);
            end
        end
    end

    time_digit_counter_bin_to_bcd2 u_bcd_hr (
        .i_bin    (w_hr_disp),
        .o_tens_c (w_hr_tens),
        .o_ones_c (w_hr_ones)
    );

    time_digit_counter_bin_to_bcd2 u_bcd_min (
        .i_bin    (r_min),
        .o_tens_c (w_min_tens),
        .o_ones_c (w_min_ones)
    );

    time_digit_counter_bin_to_bcd2 u_bcd_sec (
        .i_bin    (r_sec),
        .o_tens_c (w_sec_tens),
        .o_ones_c (w_sec_ones)
    );

    // Digit codes with 12h substitutions and the blanked field while blinking.
    always_comb begin
        w_digits_nxt.d5 = w_hr_tens;
        w_digits_nxt.d4 = w_hr_ones;
        w_digits_nxt.d3 = w_min_tens;
        w_digits_nxt.d2 = w_min_ones;
        w_digits_nxt.d1 = w_sec_tens;
        w_digits_nxt.d0 = w_sec_ones;

        if (bus.mode_12h) begin
            if (w_hr_tens == 4'd0) begin
                w_digits_nxt.d5 = CODE_BLANK;
            end
            w_digits_nxt.d1 = w_pm ? CODE_P : CODE_A;
            w_digits_nxt.d0 = CODE_BLANK;
        end

        if (r_blk_hide && (r_state == ST_SET_HR)) begin
            w_digits_nxt.d5 = CODE_BLANK;
            w_digits_nxt.d4 = CODE_BLANK;
        end
        if (r_blk_hide && (r_state == ST_SET_MIN)) begin
            w_digits_nxt.d3 = CODE_BLANK;
            w_digits_nxt.d2 = CODE_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_hr       <= '0;
            r_min      <= '0;
            r_sec      <= '0;
            r_pre      <= '0;
            r_blk_cnt  <= '0;
            r_blk_hide <= 1'b0;
            r_sec_tick <= 1'b0;
            r_digits   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hr       <= w_hr_nxt;
            r_min      <= w_min_nxt;
            r_sec      <= w_sec_nxt;
            r_pre      <= w_pre_nxt;
            r_blk_cnt  <= w_blk_cnt_nxt;
            r_blk_hide <= w_blk_hide_nxt;
            r_sec_tick <= w_tick_nxt;
            r_digits   <= w_digits_nxt;
        end
    end

    assign bus.digit5   = r_digits.d5;
    assign bus.digit4   = r_digits.d4;
    assign bus.digit3   = r_digits.d3;
    assign bus.digit2   = r_digits.d2;
    assign bus.digit1   = r_digits.d1;
    assign bus.digit0   = r_digits.d0;
    assign bus.state    = r_state;
    assign bus.sec_tick = r_sec_tick;

endmodule

// File: tb/tb_time_digit_counter.sv
// Bench for time_digit_counter: seconds-of-day reference model, per-cycle compare, directed and random keys.
module tb_time_digit_counter;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned BLINK_DIV = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;

    time_digit_counter_if bus();

    time_digit_counter #(
        .TICK_DIV  (TICK_DIV),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] disp(input int tod, input int st, input bit hide, input bit m12);
        int h, mi, se, hd;
        logic [3:0] d5, d4, d3, d2, d1, d0;
        h  = tod / 3600;
        mi = (tod / 60) % 60;
        se = tod % 60;
        hd = h;
        if (m12) hd = (h % 12 == 0) ? 12 : h % 12;
        d5 = 4'(hd / 10); d4 = 4'(hd % 10);
        d3 = 4'(mi / 10); d2 = 4'(mi % 10);
        d1 = 4'(se / 10); d0 = 4'(se % 10);
        if (m12) begin
            if (d5 == 4'd0) d5 = 4'hF;
            d1 = (h >= 12) ? 4'hB : 4'hA;
            d0 = 4'hF;
        end
        if (hide && st == 1) begin d5 = 4'hF; d4 = 4'hF; end
        if (hide && st == 2) begin d3 = 4'hF; d2 = 4'hF; end
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    // Reference: time as seconds of day, blink phase from cycles since the last restart.
    int          m_tod = 0;
    int          m_pre = 0;
    int          m_st  = 0;
    int          m_age = 0;
    logic [23:0] e_dig  = '0;
    logic [1:0]  e_st   = '0;
    logic        e_tick = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tod = 0; m_pre = 0; m_st = 0; m_age = 0;
            e_dig = '0; e_st = '0; e_tick = 1'b0;
        end else begin
            bit restart;
            int h, mi;
            restart = 1'b0;
            e_dig  = disp(m_tod, m_st, (m_st != 0) && (((m_age / BLINK_DIV) % 2) == 1), bus.mode_12h);
            e_tick = 1'b0;
            case (m_st)
                0: begin
                    if (bus.key_set) begin
                        m_st = 1; restart = 1'b1;
                    end else if (m_pre == TICK_DIV - 1) begin
                        m_pre = 0; e_tick = 1'b1; m_tod = (m_tod + 1) % 86400;
                    end else begin
                        m_pre++;
                    end
                end
                1: begin
                    if (bus.key_set) begin
                        m_st = 2; restart = 1'b1;
                    end else if (bus.key_inc) begin
                        h = (m_tod / 3600 + 1) % 24;
                        m_tod = h * 3600 + m_tod % 3600;
                        restart = 1'b1;
                    end
                end
                default: begin
                    if (bus.key_set) begin
                        m_st = 0; m_tod = m_tod - m_tod % 60; m_pre = 0;
                    end else if (bus.key_inc) begin
                        mi = ((m_tod / 60) % 60 + 1) % 60;
                        m_tod = (m_tod / 3600) * 3600 + mi * 60 + m_tod % 60;
                        restart = 1'b1;
                    end
                end
            endcase
            m_age = restart ? 0 : m_age + 1;
            e_st  = 2'(m_st);
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("cyc_digits", {bus.digit5, bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0}, e_dig);
            chk("cyc_state", 24'(bus.state), 24'(e_st));
            chk("cyc_tick", 24'(bus.sec_tick), 24'(e_tick));
        end
    end

    function automatic logic [23:0] dig();
        return {bus.digit5, bus.digit4, bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_set();
        bus.key_set = 1'b1; step(1); bus.key_set = 1'b0;
    endtask

    task automatic pulse_inc();
        bus.key_inc = 1'b1; step(1); bus.key_inc = 1'b0;
    endtask

    task automatic do_reset();
        bus.mode_12h = 1'b0; bus.key_set = 1'b0; bus.key_inc = 1'b0;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.sec_tick) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("tick_timeout", 24'd0, 24'd1);
    endtask

    task automatic set_time(input int h, input int m);
        do_reset();
        pulse_set();
        repeat (h) pulse_inc();
        pulse_set();
        repeat (m) pulse_inc();
        pulse_set();
    endtask

    initial begin
        int n;
        bus.mode_12h = 1'b0; bus.key_set = 1'b0; bus.key_inc = 1'b0;

        // Reset values and the first tick
        do_reset();
        chk("rst_digits", dig(), 24'h000000);
        chk("rst_state", 24'(bus.state), 24'd0);
        chk("rst_tick", 24'(bus.sec_tick), 24'd0);
        wait_tick(n);
        chk("first_tick_cycle", 24'(n), 24'd4);

        do_reset();
        bus.mode_12h = 1'b1;
        step(1);
        chk("rst_12h_digits", dig(), 24'h1200AF);

        // 23:59 set, run a full minute and roll over midnight
        set_time(23, 59);
        step(1);
        chk("set_2359", dig(), 24'h235900);
        wait_tick(n);
        for (int t = 2; t <= 59; t++) begin
            wait_tick(n);
            chk("tick_gap", 24'(n), 24'd4);
        end
        step(1);
        chk("at_235959", dig(), 24'h235959);
        wait_tick(n);
        step(1);
        chk("rollover", dig(), 24'h000000);
        pulse_inc();
        step(1);
        chk("run_inc_ignored", dig(), 24'h000000);

        // 12h conversions
        bus.mode_12h = 1'b1;
        set_time(13, 5);
        bus.mode_12h = 1'b1;
        step(1);
        chk("h12_1305", dig(), 24'hF105BF);
        set_time(12, 5);
        bus.mode_12h = 1'b1;
        step(1);
        chk("h12_1205", dig(), 24'h1205BF);
        set_time(0, 5);
        bus.mode_12h = 1'b1;
        step(1);
        chk("h12_0005", dig(), 24'h1205AF);

        // Blink in SET_HR, key_inc during the hidden phase
        do_reset();
        pulse_set();
        repeat (7) pulse_inc();
        step(1);
        chk("blink_visible", dig(), 24'h070000);
        step(3);
        chk("blink_hidden", dig(), 24'hFF0000);
        pulse_inc();
        step(1);
        chk("inc_reveals", dig(), 24'h080000);
        repeat (23) pulse_inc();

        // key_set beats key_inc
        bus.key_set = 1'b1; bus.key_inc = 1'b1;
        step(1);
        bus.key_set = 1'b0; bus.key_inc = 1'b0;
        chk("set_wins_state", 24'(bus.state), 24'd2);
        step(1);
        chk("set_wins_hr", dig(), 24'h070000);
        repeat (42) pulse_inc();
        step(1);
        chk("min_42", dig(), 24'h074200);

        // Asynchronous reset mid-edit
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_digits", dig(), 24'h000000);
        chk("async_rst_state", 24'(bus.state), 24'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_tick(n);
        chk("resume_tick", 24'(n), 24'd4);
        step(1);
        chk("resume_digits", dig(), 24'h000001);

        // Random keys and mode changes against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            bus.key_set = ($urandom_range(0, 39) == 0);
            bus.key_inc = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 99) == 0) bus.mode_12h = ~bus.mode_12h;
            step(1);
        end
        bus.key_set = 1'b0; bus.key_inc = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_digit_counter.md
Name: time_digit_counter

Overview:
Time-of-day counter that produces six 4-bit digit codes, one for each downstream 7-segment hex decoder instance. It counts hours, minutes and seconds, and supports 24h display and 12h display with an A/P indicator. A small set-mode FSM lets the user edit hours and minutes from two key pulses. The field being edited blinks by substituting the blank code.

Parameters:
TICK_DIV, 50000000, clk cycles per second tick (>=2)
BLINK_DIV, 12500000, clk cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mode_12h  input  1  1 = 12h display with A/P, 0 = 24h display
key_set  input  1  one-cycle pulse (already debounced/synchronised), advances set FSM
key_inc  input  1  one-cycle pulse, increments the selected field in a set state
digit5  output  4  hour tens code
digit4  output  4  hour ones code
digit3  output  4  minute tens code
digit2  output  4  minute ones code
digit1  output  4  second tens code (24h) / A=10 or P=11 (12h)
digit0  output  4  second ones code (24h) / blank=15 (12h)
state  output  2  00 RUN, 01 SET_HR, 10 SET_MIN
sec_tick  output  1  one-cycle pulse when seconds advance

Behaviour:
- Internal time is binary: hr 0-23 (5b), min 0-59 (6b), sec 0-59 (6b), prescaler 0..TICK_DIV-1.
- Reset: hr=min=sec=0, prescaler=0, state=RUN, blink phase visible, blink counter 0, sec_tick=0.
- Digit outputs after reset reflect 00:00:00 in the current mode, with no blinking:
  - 24h mode: all digits = 0.
  - 12h mode: digits = 1,2,0,0,10,15.
- Digit outputs are registered: they reflect internal state as of the previous clock edge (1-cycle latency).
- RUN: prescaler increments each cycle. At TICK_DIV-1 it wraps to 0, sec_tick=1 for that cycle, and sec increments.
  - sec 59 wraps to 0 and carries to min; min 59 wraps to 0 and carries to hr; hr 23 wraps to 0. 23:59:59 wraps to 00:00:00 on one tick.
- Set FSM on key_set: RUN->SET_HR->SET_MIN->RUN.
  - Entering SET_HR: prescaler holds.
  - SET_MIN->RUN: sec=0 and prescaler=0, so the first tick comes TICK_DIV cycles later.
- In SET_HR/SET_MIN, prescaler and sec are frozen and sec_tick=0.
- key_inc in SET_HR: hr=(hr+1) mod 24. In SET_MIN: min=(min+1) mod 60. There is no carry into other fields. key_inc is ignored in RUN.
- key_set and key_inc in the same cycle: key_set wins and key_inc is dropped.
- 12h conversion:
  - hr 0 -> 12 A; 1-11 -> hr A; 12 -> 12 P; 13-23 -> hr-12 P.
  - A leading hour-tens zero is blanked (digit5=15).
  - In 24h mode the leading zero is shown (0).
- mode_12h changes take effect on display on the next cycle only; counting is unaffected.
- Blink:
  - The blink counter runs only in set states and toggles the phase every BLINK_DIV cycles.
  - Entering any set state, and each accepted key_inc, reset the counter to 0 with phase visible.
  - In the hidden phase, the selected field's two digits = 15: digit5/4 in SET_HR, digit3/2 in SET_MIN. All other digits stay steady.
  - In RUN the phase is forced visible.
- Reset asserted mid-edit aborts the edit and returns to RUN at 00:00:00.

Decomposition:
- Shared package (included header, localparams):
  - Digit codes: CODE_A=10, CODE_P=11, CODE_BLANK=15.
  - State encodings: ST_RUN, ST_SET_HR, ST_SET_MIN.
  - Limits: 23 and 59.
- One sub-module: bin_to_bcd2 (combinational, 0-59 -> tens/ones 4b each). It is instantiated for hour (after 12h mapping), minute and second.
- Everything else lives in time_digit_counter.

Test Plan:
Use TICK_DIV=4, BLINK_DIV=3 for all scenarios.
- Reset, then check digit outputs and tick timing:
  - mode_12h=0 -> digits 0,0,0,0,0,0, state=00.
  - mode_12h=1 -> 1,2,0,0,10,15.
  - First sec_tick occurs on cycle 4 after reset release.
- Enter SET_HR, 23 key_inc; SET_MIN, 59 key_inc; key_set to RUN; wait 60 ticks:
  - Display 23:59:00 then 23:59:59, then 00:00:00 on the next tick.
  - sec_tick pulses every 4 cycles.
- Set 13:05, mode_12h=1 -> digit5=15, digit4=1, digit3=0, digit2=5, digit1=11, digit0=15. Set hr=12 -> digit1=11; hr=0 -> 1,2 with A.
- In SET_HR:
  - digit5/4 alternate between value and 15 every 3 cycles, starting visible.
  - digit3..0 stay steady.
  - A key_inc mid-hidden phase makes the hour immediately visible (incremented).
- In SET_HR at hr=7, assert key_set and key_inc in the same cycle -> state=10, hr stays 7. key_inc while in RUN -> no change to any field.
- In SET_MIN with min=42, pulse rst_n low asynchronously mid-cycle:
  - Digits are 0 with state=00 before the next clk edge.
  - Counting resumes from 00:00:00.
